// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the push-button debouncer:
//   - key_state_e          : debouncer FSM state encoding (also exported on the
//                            debug state port of key_debounce)
//   - *_1MS/_500MS/_100MS  : default timing constants at a 100 MHz clock
//   - max3()               : helper used to size the shared counter width
// -----------------------------------------------------------------------------
package key_pkg;

    localparam int DEBOUNCE_CYCLES_1MS = 100000;
    localparam int REPEAT_DELAY_500MS  = 50000000;
    localparam int REPEAT_PERIOD_100MS = 10000000;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } key_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Both flops clear on the synchronous reset.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   i_d  : asynchronous input level
//   o_q  : synchronized level (i_d delayed by two clk edges)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Debounces one raw push-button level and generates press / release / auto-
// repeat pulses. The key must be seen stable for DEBOUNCE_CYCLES consecutive
// synchronized samples before a level change is accepted.
// Ports:
//   clk         : system clock (only clock)
//   rst         : synchronous active-high reset
//   key_in      : raw asynchronous key level, 1 = pressed
//   key_level   : debounced level (1 in HELD and RELEASE_CHK)
//   key_press   : one-cycle pulse in the first HELD cycle after a press
//   key_release : one-cycle pulse in the first IDLE cycle after a release
//   key_repeat  : one-cycle pulse per auto-repeat tick while held
//   o_dbg_state : current FSM state, for observation only
// -----------------------------------------------------------------------------
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_1MS,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       key_repeat,
    output key_state_e o_dbg_state
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             w_sync;
    key_state_e       r_state;
    key_state_e       w_next;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] w_db_cnt_next;
    logic [CNT_W-1:0] w_db_cnt_inc;
    logic [CNT_W-1:0] r_rep_cnt;
    logic             r_rep_armed;
    logic             w_press;
    logic             w_release;
    logic             w_rep_run;
    logic             w_rep_hit;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_repeat;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (key_in),
        .o_q (w_sync)
    );

    // Saturating increment so the counter can never wrap.
    assign w_db_cnt_inc = (r_db_cnt == CNT_MAX) ? r_db_cnt : r_db_cnt + CNT_ONE;

    always_comb begin
        w_next        = r_state;
        w_db_cnt_next = r_db_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_sync) begin
                    w_next        = ST_PRESS_CHK;
                    w_db_cnt_next = CNT_ONE;
                end else begin
                    w_db_cnt_next = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!w_sync) begin
                    // Any bounce restarts the qualification from scratch.
                    w_next        = ST_IDLE;
                    w_db_cnt_next = '0;
                end else if (r_db_cnt >= DB_LAST) begin
                    w_next        = ST_HELD;
                    w_db_cnt_next = '0;
                end else begin
                    w_db_cnt_next = w_db_cnt_inc;
                end
            end
            ST_HELD: begin
                if (!w_sync) begin
                    w_next        = ST_RELEASE_CHK;
                    w_db_cnt_next = CNT_ONE;
                end else begin
                    w_db_cnt_next = '0;
                end
            end
            ST_RELEASE_CHK: begin
                if (w_sync) begin
                    w_next        = ST_HELD;
                    w_db_cnt_next = '0;
                end else if (r_db_cnt >= DB_LAST) begin
                    w_next        = ST_IDLE;
                    w_db_cnt_next = '0;
                end else begin
                    w_db_cnt_next = w_db_cnt_inc;
                end
            end
            default: begin
                w_next        = ST_IDLE;
                w_db_cnt_next = '0;
            end
        endcase
    end

    // Pulses are decoded from the transition and registered together with the
    // state, so each appears in the first cycle of the new state.
    assign w_press   = (r_state == ST_PRESS_CHK)   && (w_next == ST_HELD);
    assign w_release = (r_state == ST_RELEASE_CHK) && (w_next == ST_IDLE);

    // The repeat schedule only advances on edges that stay in HELD; the edge
    // leaving HELD and all RELEASE_CHK edges leave it frozen, so a bounce back
    // to HELD resumes where it stopped.
    assign w_rep_run = (r_state == ST_HELD) && (w_next == ST_HELD);
    assign w_rep_hit = REPEAT_EN && w_rep_run &&
                       (r_rep_cnt == (r_rep_armed ? RP_LAST : RD_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_db_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_db_cnt <= w_db_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_press) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_hit) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b1;
        end else if (w_rep_run && (r_rep_cnt != CNT_MAX)) begin
            r_rep_cnt   <= r_rep_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_level   <= (w_next == ST_HELD) || (w_next == ST_RELEASE_CHK);
            r_press   <= w_press;
            r_release <= w_release;
            r_repeat  <= w_rep_hit;
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_repeat  = r_repeat;
    assign o_dbg_state = r_state;

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 100000, consecutive stable samples required to accept a level change (1 ms at 100 MHz).
REQ-002 Parameter REPEAT_EN, default 1, enables auto-repeat pulses while the key is held (0 = disabled).
REQ-003 Parameter REPEAT_DELAY, default 50000000, cycles in HELD before the first repeat pulse (500 ms).
REQ-004 Parameter REPEAT_PERIOD, default 10000000, cycles between subsequent repeat pulses (100 ms).
REQ-005 Port clk  input  1  system clock, 100 MHz; the only clock.
REQ-006 Port rst  input  1  reset; synchronous, active-high.
REQ-007 Port key_in  input  1  raw asynchronous push-button level (s_2/s_3 style), 1 = pressed.
REQ-008 Port key_level  output  1  debounced key level.
REQ-009 Port key_press  output  1  one-cycle pulse on accepted press.
REQ-010 Port key_release  output  1  one-cycle pulse on accepted release.
REQ-011 Port key_repeat  output  1  one-cycle pulse per auto-repeat tick while held.

Function
REQ-012 key_in SHALL pass through a two-flop synchronizer; key_sync denotes its output (key_in delayed 2 cycles).
REQ-013 FSM states SHALL be IDLE, PRESS_CHK, HELD, RELEASE_CHK.
REQ-014 IDLE: key_sync=1 -> PRESS_CHK with debounce counter = 1; otherwise stay.
REQ-015 PRESS_CHK: key_sync=1 increments counter; key_sync=0 -> IDLE, counter cleared (any bounce restarts the count).
REQ-016 PRESS_CHK with key_sync=1 and counter = DEBOUNCE_CYCLES-1 -> HELD; key_press SHALL be 1 in the first HELD cycle only.
REQ-017 Press latency SHALL be exactly DEBOUNCE_CYCLES+2 cycles from the first clock edge sampling key_in=1 to key_press=1, for a bounce-free input.
REQ-018 HELD: key_sync=0 -> RELEASE_CHK, counter = 1; RELEASE_CHK mirrors PRESS_CHK with inverted level, returning to HELD on key_sync=1.
REQ-019 RELEASE_CHK completion -> IDLE; key_release SHALL be 1 in the first IDLE cycle only, with the same latency as REQ-017.
REQ-020 key_level SHALL be 1 in HELD and RELEASE_CHK, and 0 in IDLE and PRESS_CHK.
REQ-021 Repeat counter SHALL run only in HELD; it is cleared on HELD entry and frozen (not cleared) in RELEASE_CHK.
REQ-022 With REPEAT_EN=1, key_repeat SHALL pulse after REPEAT_DELAY cycles in HELD, then every REPEAT_PERIOD cycles; it never coincides with key_press.
REQ-023 A bounce (RELEASE_CHK -> HELD) SHALL resume the repeat schedule without emitting key_press.
REQ-024 With REPEAT_EN=0, key_repeat SHALL be constant 0.
REQ-025 Counter widths SHALL be $clog2 of the largest parameter +1; counters SHALL saturate and never wrap.
REQ-026 key_press, key_release and key_repeat SHALL be mutually exclusive in any cycle, and all outputs SHALL be registered.

Reset
REQ-027 rst=1 SHALL force IDLE, clear both counters and both synchronizer flops, and drive key_level, key_press, key_release and key_repeat to 0 on the next edge.
REQ-028 Reset asserted mid-HELD SHALL NOT produce key_release; a key still held after reset SHALL yield a fresh key_press after the full REQ-017 latency.

Structure
REQ-029 Package key_pkg SHALL hold the state enum typedef and the default constants: DEBOUNCE_CYCLES_1MS, REPEAT_DELAY_500MS and REPEAT_PERIOD_100MS.
REQ-030 The synchronizer SHALL be a separate sub-module sync_2ff; each button (s_2, s_3) gets its own key_debounce instance feeding led_display_ctrl.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 unless stated)
REQ-031 Reset, then key_in=1 stable from cycle 0 -> key_press=1 in cycle 6 only, and key_level=1 from cycle 6.
REQ-032 key_in pattern 1,1,0,1,1,1,1 -> no press until 4 consecutive synchronized 1s; key_press fires 6 cycles after the final rising edge.
REQ-033 Hold 30 cycles past key_press -> key_repeat at +10, +13, +16, +19, +22, +25, +28, and no key_press repeats.
REQ-034 Release after hold -> key_release exactly 6 cycles after key_in falls, key_level=0 the same cycle; a 2-cycle release glitch -> no key_release and repeat cadence continues.
REQ-035 rst pulse while HELD with key_in still 1 -> outputs 0 the next cycle, no key_release, and a new key_press 6 cycles after rst deasserts.
REQ-036 Defaults, 1 ms s_3 hold at 100 MHz -> exactly one key_press, 100002 cycles after the rise; REPEAT_EN=0 -> key_repeat never asserts.
